// File: rtl/asmi_arbiter_if.sv
// Signal bundle between the two ASMI requesters, the arbiter and the ASMI macro.
// master: the surrounding system (requesters + flash macro); slave: the arbiter.
interface asmi_arbiter_if #(
    parameter int ADDR_W = 24
);
    // requester 0 (remote-programming engine)
    logic              req0;
    logic              grant0;
    logic [ADDR_W-1:0] addr0;
    logic              wren0;
    logic              sector_erase0;
    logic              write0;
    logic              shift_bytes0;
    logic              rden0;
    logic              read0;
    logic [7:0]        datain0;
    logic              busy0;

    // requester 1 (flash read-back engine)
    logic              req1;
    logic              grant1;
    logic [ADDR_W-1:0] addr1;
    logic              wren1;
    logic              sector_erase1;
    logic              write1;
    logic              shift_bytes1;
    logic              rden1;
    logic              read1;
    logic [7:0]        datain1;
    logic              busy1;

    // ASMI macro side
    logic [ADDR_W-1:0] asmi_addr;
    logic              asmi_wren;
    logic              asmi_sector_erase;
    logic              asmi_write;
    logic              asmi_shift_bytes;
    logic              asmi_rden;
    logic              asmi_read;
    logic [7:0]        asmi_datain;
    logic              asmi_busy;

    // watchdog reporting
    logic              timeout_err;
    logic              timeout_port;

    modport master (
        output req0, addr0, wren0, sector_erase0, write0, shift_bytes0, rden0, read0, datain0,
        output req1, addr1, wren1, sector_erase1, write1, shift_bytes1, rden1, read1, datain1,
        output asmi_busy,
        input  grant0, grant1, busy0, busy1,
        input  asmi_addr, asmi_wren, asmi_sector_erase, asmi_write, asmi_shift_bytes,
        input  asmi_rden, asmi_read, asmi_datain,
        input  timeout_err, timeout_port
    );

    modport slave (
        input  req0, addr0, wren0, sector_erase0, write0, shift_bytes0, rden0, read0, datain0,
        input  req1, addr1, wren1, sector_erase1, write1, shift_bytes1, rden1, read1, datain1,
        input  asmi_busy,
        output grant0, grant1, busy0, busy1,
        output asmi_addr, asmi_wren, asmi_sector_erase, asmi_write, asmi_shift_bytes,
        output asmi_rden, asmi_read, asmi_datain,
        output timeout_err, timeout_port
    );
endinterface

// File: rtl/asmi_arbiter.sv
// Round-robin owner arbiter for the single ASMI serial-flash macro.
// The owner's strobes are muxed straight onto the macro; handover waits for
// the flash to go idle (DRAIN) plus one quiet cycle (GUARD). A watchdog
// revokes a grant held for TIMEOUT_CYCLES and disarms that port until it
// drops its request.
module asmi_arbiter #(
    parameter int TIMEOUT_CYCLES = 25000000,
    parameter int ADDR_W         = 24
) (
    input  logic           clock,
    input  logic           reset_n,
    asmi_arbiter_if.slave  bus
);
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES) > 25) ? $clog2(TIMEOUT_CYCLES) : 25;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [2:0] {IDLE, GNT0, GNT1, DRAIN, GUARD} state_t;

    state_t            state, state_nxt;
    logic              last_owner;
    logic              armed0, armed1;
    logic [CNT_W-1:0]  cnt;
    logic              timeout_err_q;
    logic              timeout_port_q;
    logic [ADDR_W-1:0] addr_hold;

    logic granted, cnt_done, elig0, elig1, revoke0, revoke1;

    assign granted  = (state == GNT0) || (state == GNT1);
    assign cnt_done = (cnt == CNT_LAST);
    assign elig0    = bus.req0 & armed0;
    assign elig1    = bus.req1 & armed1;
    // watchdog revoke only counts while the owner still wants the flash;
    // a release landing on the last cycle is an ordinary release
    assign revoke0  = (state == GNT0) & bus.req0 & cnt_done;
    assign revoke1  = (state == GNT1) & bus.req1 & cnt_done;

    // state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // next-state: round-robin pick in IDLE, release/timeout out of a grant,
    // wait for flash idle, then one guard cycle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (elig0 && elig1) state_nxt = last_owner ? GNT0 : GNT1;
                else if (elig0)     state_nxt = GNT0;
                else if (elig1)     state_nxt = GNT1;
            end
            GNT0:    if (!bus.req0 || cnt_done) state_nxt = DRAIN;
            GNT1:    if (!bus.req1 || cnt_done) state_nxt = DRAIN;
            DRAIN:   if (!bus.asmi_busy)        state_nxt = GUARD;
            GUARD:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // grant-age counter: zero whenever nobody owns the flash, counts while granted
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)               cnt <= '0;
        else if (!granted)          cnt <= '0;
        else if (cnt != CNT_MAX)    cnt <= cnt + 1'b1;
    end

    // round-robin history and the owner address presented while draining
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_owner <= 1'b1;
            addr_hold  <= '0;
        end else begin
            if (state == GNT0) begin
                addr_hold <= bus.addr0;
                if (state_nxt == DRAIN) last_owner <= 1'b0;
            end
            if (state == GNT1) begin
                addr_hold <= bus.addr1;
                if (state_nxt == DRAIN) last_owner <= 1'b1;
            end
        end
    end

    // arming: a timed-out port must drop its request before it may win again
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            armed0 <= 1'b1;
            armed1 <= 1'b1;
        end else begin
            if (revoke0)       armed0 <= 1'b0;
            else if (!bus.req0) armed0 <= 1'b1;
            if (revoke1)       armed1 <= 1'b0;
            else if (!bus.req1) armed1 <= 1'b1;
        end
    end

    // watchdog report: one-cycle pulse on the DRAIN entry cycle, sticky port id
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            timeout_err_q  <= 1'b0;
            timeout_port_q <= 1'b0;
        end else begin
            timeout_err_q <= revoke0 | revoke1;
            if (revoke0) timeout_port_q <= 1'b0;
            if (revoke1) timeout_port_q <= 1'b1;
        end
    end

    // outputs: grants decode the state register; owner's strobes pass through
    always_comb begin
        bus.grant0            = 1'b0;
        bus.grant1            = 1'b0;
        bus.busy0             = 1'b1;
        bus.busy1             = 1'b1;
        bus.asmi_addr         = addr_hold;
        bus.asmi_wren         = 1'b0;
        bus.asmi_sector_erase = 1'b0;
        bus.asmi_write        = 1'b0;
        bus.asmi_shift_bytes  = 1'b0;
        bus.asmi_rden         = 1'b0;
        bus.asmi_read         = 1'b0;
        bus.asmi_datain       = 8'h00;
        bus.timeout_err       = timeout_err_q;
        bus.timeout_port      = timeout_port_q;
        case (state)
            GNT0: begin
                bus.grant0            = 1'b1;
                bus.busy0             = bus.asmi_busy;
                bus.asmi_addr         = bus.addr0;
                bus.asmi_wren         = bus.wren0;
                bus.asmi_sector_erase = bus.sector_erase0;
                bus.asmi_write        = bus.write0;
                bus.asmi_shift_bytes  = bus.shift_bytes0;
                bus.asmi_rden         = bus.rden0;
                bus.asmi_read         = bus.read0;
                bus.asmi_datain       = bus.datain0;
            end
            GNT1: begin
                bus.grant1            = 1'b1;
                bus.busy1             = bus.asmi_busy;
                bus.asmi_addr         = bus.addr1;
                bus.asmi_wren         = bus.wren1;
                bus.asmi_sector_erase = bus.sector_erase1;
                bus.asmi_write        = bus.write1;
                bus.asmi_shift_bytes  = bus.shift_bytes1;
                bus.asmi_rden         = bus.rden1;
                bus.asmi_read         = bus.read1;
                bus.asmi_datain       = bus.datain1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_asmi_arbiter.sv
// Bench for asmi_arbiter: directed scenarios followed by a random run, every
// cycle compared against a transaction-level model of the ownership rules.
module tb_asmi_arbiter;
    localparam int T  = 16;
    localparam int AW = 24;
    localparam int P_IDLE = 0, P_GNT = 1, P_DRAIN = 2, P_GUARD = 3;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    asmi_arbiter_if #(.ADDR_W(AW)) bus ();

    asmi_arbiter #(.TIMEOUT_CYCLES(T), .ADDR_W(AW)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    // strobe vectors as driven: {wren, sector_erase, write, shift_bytes, rden, read}
    logic [5:0] cur_s0, cur_s1;

    // model of ownership
    int          m_phase, m_own, m_cnt;
    bit          m_last, m_terr, m_tport;
    bit          m_arm [2];
    logic [AW-1:0] m_hold;

    task automatic model_reset();
        m_phase = P_IDLE; m_own = 0; m_cnt = 0;
        m_last = 1'b1; m_terr = 1'b0; m_tport = 1'b0;
        m_arm[0] = 1'b1; m_arm[1] = 1'b1;
        m_hold = '0;
    endtask

    // one rising edge of the ownership rules, from the inputs present at the edge
    task automatic model_step();
        bit r [2];
        bit t, e0, e1;
        r[0] = bus.req0; r[1] = bus.req1;
        t  = (m_phase == P_GNT) && r[m_own] && (m_cnt == T - 1);
        e0 = r[0] && m_arm[0];
        e1 = r[1] && m_arm[1];
        for (int p = 0; p < 2; p++) begin
            if (t && p == m_own) m_arm[p] = 1'b0;
            else if (!r[p])      m_arm[p] = 1'b1;
        end
        m_terr = t;
        if (t) m_tport = m_own[0];
        case (m_phase)
            P_IDLE: begin
                if (e0 || e1) begin
                    m_own   = (e0 && e1) ? (m_last ? 0 : 1) : (e0 ? 0 : 1);
                    m_phase = P_GNT;
                    m_cnt   = 0;
                end
            end
            P_GNT: begin
                m_hold = m_own ? bus.addr1 : bus.addr0;
                if (!r[m_own] || m_cnt == T - 1) begin
                    m_phase = P_DRAIN;
                    m_last  = m_own[0];
                end else m_cnt++;
            end
            P_DRAIN: if (!bus.asmi_busy) m_phase = P_GUARD;
            default: m_phase = P_IDLE;
        endcase
    endtask

    task automatic check(string tag);
        logic [1:0]    eg, og, eb, ob;
        logic [5:0]    es, os;
        logic [AW-1:0] ea;
        logic [7:0]    ed;
        bit            gnt;
        gnt = (m_phase == P_GNT);
        eg  = {gnt && m_own == 1, gnt && m_own == 0};
        es  = gnt ? (m_own == 1 ? cur_s1 : cur_s0) : 6'b0;
        ea  = gnt ? (m_own == 1 ? bus.addr1 : bus.addr0) : m_hold;
        ed  = gnt ? (m_own == 1 ? bus.datain1 : bus.datain0) : 8'h00;
        eb  = {eg[1] ? bus.asmi_busy : 1'b1, eg[0] ? bus.asmi_busy : 1'b1};
        og  = {bus.grant1, bus.grant0};
        os  = {bus.asmi_wren, bus.asmi_sector_erase, bus.asmi_write,
               bus.asmi_shift_bytes, bus.asmi_rden, bus.asmi_read};
        ob  = {bus.busy1, bus.busy0};
        checks++;
        assert (og === eg) else begin errors++; $error("FAIL %s grant got=%b want=%b", tag, og, eg); end
        checks++;
        assert (os === es) else begin errors++; $error("FAIL %s strobes got=%b want=%b", tag, os, es); end
        checks++;
        assert (bus.asmi_addr === ea) else begin errors++; $error("FAIL %s addr got=%h want=%h", tag, bus.asmi_addr, ea); end
        checks++;
        assert (bus.asmi_datain === ed) else begin errors++; $error("FAIL %s datain got=%h want=%h", tag, bus.asmi_datain, ed); end
        checks++;
        assert (ob === eb) else begin errors++; $error("FAIL %s busy got=%b want=%b", tag, ob, eb); end
        checks++;
        assert (bus.timeout_err === m_terr) else begin errors++; $error("FAIL %s timeout_err got=%b want=%b", tag, bus.timeout_err, m_terr); end
        checks++;
        assert (bus.timeout_port === m_tport) else begin errors++; $error("FAIL %s timeout_port got=%b want=%b", tag, bus.timeout_port, m_tport); end
    endtask

    task automatic apply(bit r0, bit r1, logic [5:0] a, logic [5:0] b, bit busy);
        bus.req0 = r0; bus.req1 = r1;
        cur_s0 = a; cur_s1 = b;
        {bus.wren0, bus.sector_erase0, bus.write0, bus.shift_bytes0, bus.rden0, bus.read0} = a;
        {bus.wren1, bus.sector_erase1, bus.write1, bus.shift_bytes1, bus.rden1, bus.read1} = b;
        bus.datain0 = 8'($urandom);
        bus.datain1 = 8'($urandom);
        bus.asmi_busy = busy;
    endtask

    // called just after a falling edge: drive, check, advance the model at the rising edge
    task automatic cycle(string tag, bit r0, bit r1, logic [5:0] a, logic [5:0] b, bit busy);
        apply(r0, r1, a, b, busy);
        #1 check(tag);
        @(posedge clock);
        model_step();
        @(negedge clock);
    endtask

    initial begin
        bit r0, r1;
        model_reset();
        bus.addr0 = 24'h10_0000; bus.addr1 = 24'h20_0000;
        apply(1'b1, 1'b1, 6'h3f, 6'h3f, 1'b0);
        #2 check("reset");
        @(negedge clock); reset_n = 1'b1;

        // req0 alone: grant next cycle, wren/write pass through, port 1 strobes ignored
        cycle("req0_start", 1, 0, 6'b000000, 6'b001000, 0);
        cycle("req0_wren",  1, 0, 6'b100000, 6'b001000, 0);
        cycle("req0_write", 1, 0, 6'b001000, 6'b001000, 0);
        cycle("req0_idle",  1, 0, 6'b000000, 6'b001001, 0);
        for (int i = 0; i < 4; i++) cycle("req0_rel", 0, 0, 6'b001000, 6'b001000, 0);

        // simultaneous requests after reset: port 0 first, port 1 three cycles after release
        reset_n = 1'b0; model_reset(); #1 reset_n = 1'b1;
        cycle("tie_req", 1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle("tie_g0", 1, 1, 6'b000010, 6'b000001, 0);
        for (int i = 0; i < 5; i++) cycle("tie_h1", 0, 1, 6'b000010, 6'b000001, 0);

        // owner 1 releases while flash busy for 10 cycles, port 0 pending
        for (int i = 0; i < 10; i++) cycle("busy_drain", 1, 0, 0, 6'b010000, 1);
        for (int i = 0; i < 4; i++)  cycle("busy_done", 1, 0, 6'b100000, 0, 0);
        for (int i = 0; i < 4; i++)  cycle("busy_rel", 0, 0, 0, 0, 0);

        // watchdog: req1 held 40 cycles, revoked after 16, not regranted until re-raised
        bus.addr1 = 24'hab_cdef;
        for (int i = 0; i < 40; i++) cycle("tmo_hold", 0, 1, 0, 6'b000011, 0);
        cycle("tmo_drop", 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++)  cycle("tmo_rearm", 0, 1, 0, 6'b000001, 0);
        for (int i = 0; i < 4; i++)  cycle("tmo_rel", 0, 0, 0, 0, 0);

        // both always requesting, owner drops after two cycles: grants must alternate
        for (int i = 0; i < 30; i++) begin
            r0 = !(m_phase == P_GNT && m_own == 0 && m_cnt >= 1);
            r1 = !(m_phase == P_GNT && m_own == 1 && m_cnt >= 1);
            cycle("alternate", r0, r1, 6'($urandom), 6'($urandom), 0);
        end

        // asynchronous reset during a port-0 write
        for (int i = 0; i < 3; i++) cycle("pre_rst", 1, 0, 6'b001000, 0, 0);
        apply(1, 0, 6'b001000, 0, 0);
        #1 check("pre_rst_g0");
        #1 reset_n = 1'b0; model_reset();
        #1 check("async_rst");
        @(negedge clock); reset_n = 1'b1;
        for (int i = 0; i < 3; i++) cycle("post_rst", 1, 0, 6'b001000, 0, 0);
        cycle("post_rst_rel", 0, 0, 0, 0, 0);

        // random run: sticky requests, random strobes/busy, occasional address changes
        r0 = 1'b0; r1 = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(7) == 0) r0 = !r0;
            if ($urandom_range(7) == 0) r1 = !r1;
            if ($urandom_range(15) == 0) bus.addr0 = AW'($urandom);
            if ($urandom_range(15) == 0) bus.addr1 = AW'($urandom);
            cycle("random", r0, r1, 6'($urandom), 6'($urandom), $urandom_range(3) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
